// File: rtl/prefetcher_ar_arbiter.sv
// prefetcher_ar_arbiter: round-robin AR arbiter with ID-routed R return and per-slice outstanding tracking
module prefetcher_ar_arbiter #(
   parameter int NUM_SLICES      = 4,
   parameter int ADDR_BITS       = 64,
   parameter int BURST_LEN_WIDTH = 8,
   parameter int TID_WIDTH       = 8,
   parameter int DATA_WIDTH      = 64,
   parameter int MAX_OUTSTANDING = 8,
   parameter int SEL_W           = $clog2(NUM_SLICES)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_SLICES-1:0]           s_ar_valid,
   output logic [NUM_SLICES-1:0]           s_ar_ready,
   input  logic [NUM_SLICES*ADDR_BITS-1:0] s_ar_addr,
   input  logic [NUM_SLICES*BURST_LEN_WIDTH-1:0] s_ar_len,
   input  logic [NUM_SLICES*TID_WIDTH-1:0] s_ar_id,
   input  logic [NUM_SLICES-1:0]           slice_block,
   output logic [NUM_SLICES-1:0]           slice_idle,
   output logic                            m_ar_valid,
   input  logic                            m_ar_ready,
   output logic [ADDR_BITS-1:0]            m_ar_addr,
   output logic [BURST_LEN_WIDTH-1:0]      m_ar_len,
   output logic [SEL_W+TID_WIDTH-1:0]      m_ar_id,
   input  logic                            m_r_valid,
   output logic                            m_r_ready,
   input  logic [SEL_W+TID_WIDTH-1:0]      m_r_id,
   input  logic                            m_r_last,
   input  logic [DATA_WIDTH-1:0]           m_r_data,
   output logic [NUM_SLICES-1:0]           s_r_valid,
   input  logic [NUM_SLICES-1:0]           s_r_ready,
   output logic [TID_WIDTH-1:0]            s_r_id,
   output logic                            s_r_last,
   output logic [DATA_WIDTH-1:0]           s_r_data,
   output logic                            err_sticky
);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
   logic [SEL_W-1:0]           r_rr_ptr;
   logic [CNT_W-1:0]           r_cnt [NUM_SLICES];
   logic                       r_ar_valid;
   logic [ADDR_BITS-1:0]       r_ar_addr;
   logic [BURST_LEN_WIDTH-1:0] r_ar_len;
   logic [SEL_W+TID_WIDTH-1:0] r_ar_id;
   logic                       r_err;
   logic [NUM_SLICES-1:0]      w_elig, w_inc, w_dec;
   logic                       w_free, w_grant, w_sel_ok, w_retire, w_uflow;
   logic [SEL_W-1:0]           w_win, w_sel;
   assign w_sel      = m_r_id[TID_WIDTH +: SEL_W];
   assign w_sel_ok   = int'(w_sel) < NUM_SLICES;
   assign s_r_valid  = (w_sel_ok & m_r_valid) ? NUM_SLICES'(1) << w_sel : '0;
   assign m_r_ready  = w_sel_ok ? s_r_ready[w_sel] : 1'b1;
   assign w_retire   = m_r_valid & m_r_ready & m_r_last & w_sel_ok;
   assign s_r_id     = m_r_id[TID_WIDTH-1:0];
   assign s_r_last   = m_r_last;
   assign s_r_data   = m_r_data;
   assign w_free     = ~r_ar_valid | m_ar_ready;
   assign s_ar_ready = w_grant ? NUM_SLICES'(1) << w_win : '0;
   assign m_ar_valid = r_ar_valid;
   assign m_ar_addr  = r_ar_addr;
   assign m_ar_len   = r_ar_len;
   assign m_ar_id    = r_ar_id;
   assign err_sticky = r_err;
   // eligibility, counter deltas, idle flags and underflow detection per slice
   always_comb begin
      w_uflow = 1'b0;
      for (int i = 0; i < NUM_SLICES; i++) begin
         w_elig[i]     = s_ar_valid[i] & ~slice_block[i] & (r_cnt[i] < MAX_CNT);
         w_inc[i]      = w_grant & (w_win == SEL_W'(i));
         w_dec[i]      = w_retire & (w_sel == SEL_W'(i));
         w_uflow       = w_uflow | (w_dec[i] & ~w_inc[i] & (r_cnt[i] == '0));
         slice_idle[i] = (r_cnt[i] == '0) & ~(r_ar_valid & (r_ar_id[TID_WIDTH +: SEL_W] == SEL_W'(i)));
      end
   end
   // round-robin scan starting just after the last winner
   always_comb begin
      w_grant = 1'b0;
      w_win   = '0;
      for (int k = 1; k <= NUM_SLICES; k++) begin
         if (!w_grant && w_free && w_elig[(int'(r_rr_ptr) + k) % NUM_SLICES]) begin
            w_grant = 1'b1;
            w_win   = SEL_W'((int'(r_rr_ptr) + k) % NUM_SLICES);
         end
      end
   end
   // registered AR output stage and round-robin pointer
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ar_valid <= 1'b0;
         r_ar_addr  <= '0;
         r_ar_len   <= '0;
         r_ar_id    <= '0;
         r_rr_ptr   <= SEL_W'(NUM_SLICES - 1);
      end else if (w_grant) begin
         r_ar_valid <= 1'b1;
         r_ar_addr  <= s_ar_addr[int'(w_win)*ADDR_BITS +: ADDR_BITS];
         r_ar_len   <= s_ar_len[int'(w_win)*BURST_LEN_WIDTH +: BURST_LEN_WIDTH];
         r_ar_id    <= {w_win, s_ar_id[int'(w_win)*TID_WIDTH +: TID_WIDTH]};
         r_rr_ptr   <= w_win;
      end else if (m_ar_ready) begin
         r_ar_valid <= 1'b0;
      end
   end
   // outstanding counters; a grant and retire on the same slice cancel out
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_SLICES; i++) r_cnt[i] <= '0;
         r_err <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_SLICES; i++) begin
            if (w_inc[i] && !w_dec[i]) r_cnt[i] <= r_cnt[i] + 1'b1;
            else if (w_dec[i] && !w_inc[i] && r_cnt[i] != '0) r_cnt[i] <= r_cnt[i] - 1'b1;
         end
         r_err <= r_err | (m_r_valid & ~w_sel_ok) | w_uflow;
      end
   end
endmodule

// File: tb/tb_prefetcher_ar_arbiter.sv
// tb_prefetcher_ar_arbiter: table, directed and randomized checks against a cycle-level reference model
module tb_prefetcher_ar_arbiter;
   localparam int N = 4, A = 32, L = 8, T = 8, D = 32, MAXO = 2, S = 2;
   logic clk = 1'b0, reset;
   logic [N-1:0] s_ar_valid, s_ar_ready, slice_block, slice_idle, s_r_valid, s_r_ready;
   logic [N*A-1:0] s_ar_addr;
   logic [N*L-1:0] s_ar_len;
   logic [N*T-1:0] s_ar_id;
   logic m_ar_valid, m_ar_ready, m_r_valid, m_r_ready, m_r_last, s_r_last, err_sticky;
   logic [A-1:0] m_ar_addr;
   logic [L-1:0] m_ar_len;
   logic [S+T-1:0] m_ar_id, m_r_id;
   logic [D-1:0] m_r_data, s_r_data;
   logic [T-1:0] s_r_id;
   logic [2:0] d3_s_ar_ready, d3_slice_idle, d3_s_r_valid, d3_s_r_ready;
   logic d3_m_ar_valid, d3_m_r_valid, d3_m_r_ready, d3_s_r_last, d3_err;
   logic [A-1:0] d3_m_ar_addr;
   logic [L-1:0] d3_m_ar_len;
   logic [S+T-1:0] d3_m_ar_id, d3_m_r_id;
   logic [T-1:0] d3_s_r_id;
   logic [D-1:0] d3_s_r_data;
   int checks = 0, errors = 0;
   int cnt [N];
   int rr, win, sel;
   bit mv, merr, g, e_mrr;
   logic [A-1:0] ma;
   logic [L-1:0] ml;
   logic [S+T-1:0] mid;
   logic [N-1:0] e_ready, e_srv, e_idle;
   typedef struct {
      logic v;
      logic [S+T-1:0] id;
      logic [N-1:0] rdy;
      logic [N-1:0] srv;
      logic mrr;
   } rvec_t;
   rvec_t tbl [6];
   always #5 clk = ~clk;
   prefetcher_ar_arbiter #(.NUM_SLICES(N), .ADDR_BITS(A), .BURST_LEN_WIDTH(L), .TID_WIDTH(T),
      .DATA_WIDTH(D), .MAX_OUTSTANDING(MAXO)) u_dut (
      .clk(clk), .reset(reset), .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
      .s_ar_len(s_ar_len), .s_ar_id(s_ar_id), .slice_block(slice_block), .slice_idle(slice_idle),
      .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len),
      .m_ar_id(m_ar_id), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_id(m_r_id), .m_r_last(m_r_last),
      .m_r_data(m_r_data), .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_id(s_r_id),
      .s_r_last(s_r_last), .s_r_data(s_r_data), .err_sticky(err_sticky));
   prefetcher_ar_arbiter #(.NUM_SLICES(3), .ADDR_BITS(A), .BURST_LEN_WIDTH(L), .TID_WIDTH(T),
      .DATA_WIDTH(D), .MAX_OUTSTANDING(MAXO)) u_dut3 (
      .clk(clk), .reset(reset), .s_ar_valid(3'b000), .s_ar_ready(d3_s_ar_ready), .s_ar_addr({3*A{1'b0}}),
      .s_ar_len({3*L{1'b0}}), .s_ar_id({3*T{1'b0}}), .slice_block(3'b000), .slice_idle(d3_slice_idle),
      .m_ar_valid(d3_m_ar_valid), .m_ar_ready(1'b1), .m_ar_addr(d3_m_ar_addr), .m_ar_len(d3_m_ar_len),
      .m_ar_id(d3_m_ar_id), .m_r_valid(d3_m_r_valid), .m_r_ready(d3_m_r_ready), .m_r_id(d3_m_r_id),
      .m_r_last(1'b1), .m_r_data({D{1'b0}}), .s_r_valid(d3_s_r_valid), .s_r_ready(d3_s_r_ready),
      .s_r_id(d3_s_r_id), .s_r_last(d3_s_r_last), .s_r_data(d3_s_r_data), .err_sticky(d3_err));
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic model_reset();
      for (int i = 0; i < N; i++) cnt[i] = 0;
      rr = N - 1; mv = 0; ma = '0; ml = '0; mid = '0; merr = 0;
   endtask
   task automatic eval();
      bit free;
      free = !mv || m_ar_ready;
      g = 0; win = 0;
      for (int k = 1; k <= N; k++) begin
         int j;
         j = (rr + k) % N;
         if (!g && free && s_ar_valid[j] && !slice_block[j] && cnt[j] < MAXO) begin g = 1; win = j; end
      end
      e_ready = g ? N'(1 << win) : '0;
      sel = int'(m_r_id[T +: S]);
      e_srv = m_r_valid ? N'(1 << sel) : '0;
      e_mrr = s_r_ready[sel];
      for (int i = 0; i < N; i++) e_idle[i] = cnt[i] == 0 && !(mv && int'(mid[T +: S]) == i);
   endtask
   task automatic update();
      bit ret;
      if (reset) begin model_reset(); return; end
      ret = m_r_valid && e_mrr && m_r_last;
      if (ret && !(g && win == sel)) begin
         if (cnt[sel] == 0) merr = 1; else cnt[sel]--;
      end
      if (g && !(ret && win == sel)) cnt[win]++;
      if (g) begin
         mv = 1; ma = s_ar_addr[win*A +: A]; ml = s_ar_len[win*L +: L];
         mid = {S'(win), s_ar_id[win*T +: T]}; rr = win;
      end else if (m_ar_ready) mv = 0;
   endtask
   task automatic step();
      #1;
      eval();
      chk("s_ar_ready", s_ar_ready, e_ready);
      chk("m_ar_valid", m_ar_valid, mv);
      chk("m_ar_addr", m_ar_addr, ma);
      chk("m_ar_len", m_ar_len, ml);
      chk("m_ar_id", m_ar_id, mid);
      chk("s_r_valid", s_r_valid, e_srv);
      chk("m_r_ready", m_r_ready, e_mrr);
      chk("s_r_id", s_r_id, m_r_id[T-1:0]);
      chk("slice_idle", slice_idle, e_idle);
      chk("err_sticky", err_sticky, merr);
      @(posedge clk);
      update();
      @(negedge clk);
   endtask
   task automatic do_reset();
      reset = 1; s_ar_valid = '0; m_r_valid = 0; m_r_last = 0; slice_block = '0; m_ar_ready = 1;
      step(); step();
      reset = 0;
   endtask
   initial begin
      reset = 1; s_ar_valid = '0; slice_block = '0; m_ar_ready = 1; m_r_valid = 0; m_r_id = '0;
      m_r_last = 0; m_r_data = '0; s_r_ready = '0; s_ar_addr = '0; s_ar_len = '0; s_ar_id = '0;
      d3_m_r_valid = 0; d3_m_r_id = '0; d3_s_r_ready = '0;
      repeat (2) @(negedge clk);
      model_reset();
      reset = 0;
      chk("rst_valid", m_ar_valid, 0);
      chk("rst_idle", slice_idle, 4'hF);
      chk("rst_err", err_sticky, 0);
      tbl[0] = '{1'b1, 10'h0AA, 4'b0001, 4'b0001, 1'b1};
      tbl[1] = '{1'b1, 10'h1AA, 4'b0001, 4'b0010, 1'b0};
      tbl[2] = '{1'b1, 10'h255, 4'b0100, 4'b0100, 1'b1};
      tbl[3] = '{1'b0, 10'h355, 4'b1000, 4'b0000, 1'b1};
      tbl[4] = '{1'b1, 10'h3FF, 4'b0111, 4'b1000, 1'b0};
      tbl[5] = '{1'b0, 10'h100, 4'b0000, 4'b0000, 1'b0};
      for (int i = 0; i < 6; i++) begin
         m_r_valid = tbl[i].v; m_r_id = tbl[i].id; s_r_ready = tbl[i].rdy; m_r_last = 0;
         #1;
         chk("tbl_s_r_valid", s_r_valid, tbl[i].srv);
         chk("tbl_m_r_ready", m_r_ready, tbl[i].mrr);
         chk("tbl_s_r_id", s_r_id, tbl[i].id[T-1:0]);
      end
      m_r_valid = 0; s_r_ready = '0;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         s_ar_addr[i*A +: A] = 32'h100 * i; s_ar_len[i*L +: L] = L'(i); s_ar_id[i*T +: T] = T'(i);
      end
      s_ar_valid = 4'hF;
      for (int c = 0; c < 8; c++) begin
         #1;
         chk("rr_grant", s_ar_ready, 4'b1 << (c % 4));
         if (c > 0) chk("rr_prefix", m_ar_id[T +: S], (c - 1) % 4);
         step();
      end
      #1;
      chk("rr_last_prefix", m_ar_id[T +: S], 3);
      chk("rr_all_full", s_ar_ready, 0);
      do_reset();
      s_ar_addr[2*A +: A] = 32'h1000; s_ar_len[2*L +: L] = 8'd3; s_ar_id[2*T +: T] = 8'h05;
      s_ar_valid = 4'b0100; m_ar_ready = 0;
      step();
      s_ar_valid = 4'b0110;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("stall_valid", m_ar_valid, 1);
         chk("stall_addr", m_ar_addr, 32'h1000);
         chk("stall_len", m_ar_len, 3);
         chk("stall_id", m_ar_id, 10'h205);
         chk("stall_ready", s_ar_ready, 0);
         step();
      end
      reset = 1; s_ar_valid = '0;
      step();
      reset = 0;
      chk("rst_stall_valid", m_ar_valid, 0);
      chk("rst_stall_idle", slice_idle, 4'hF);
      m_ar_ready = 1; s_ar_valid = 4'b0010;
      step(); step();
      #1;
      chk("max_block", s_ar_ready, 0);
      chk("max_idle1", slice_idle[1], 0);
      step();
      m_r_valid = 1; m_r_id = {2'd1, 8'h33}; m_r_last = 1; s_r_ready = 4'b0010;
      #1;
      chk("max_still", s_ar_ready, 0);
      step();
      m_r_valid = 0; m_r_last = 0;
      #1;
      chk("max_resume", s_ar_ready, 4'b0010);
      step();
      do_reset();
      s_ar_valid = 4'b1000;
      step();
      s_ar_valid = 0;
      step();
      begin
         int beat;
         bit tog;
         beat = 0; tog = 0;
         for (int c = 0; c < 20 && beat < 4; c++) begin
            m_r_valid = 1; m_r_id = {2'd3, 8'h07}; m_r_last = (beat == 3); s_r_ready = tog ? 4'b1000 : 4'b0000;
            #1;
            chk("r4_s_r_valid", s_r_valid, 4'b1000);
            chk("r4_m_r_ready", m_r_ready, tog);
            chk("r4_s_r_id", s_r_id, 8'h07);
            chk("r4_idle3", slice_idle[3], 0);
            if (tog) beat++;
            tog = ~tog;
            step();
         end
         chk("r4_beats", beat, 4);
      end
      m_r_valid = 0; m_r_last = 0;
      #1;
      chk("r4_idle_after", slice_idle[3], 1);
      do_reset();
      s_ar_valid = 4'b0001;
      step();
      s_ar_valid = 4'b0011; slice_block = 4'b0001;
      #1;
      chk("blk_grant", s_ar_ready, 4'b0010);
      step();
      #1;
      chk("blk_grant2", s_ar_ready, 4'b0010);
      chk("blk_idle0", slice_idle[0], 0);
      step();
      s_ar_valid = 0;
      m_r_valid = 1; m_r_id = 10'h011; m_r_last = 1; s_r_ready = 4'b0001;
      step();
      m_r_valid = 0; m_r_last = 0;
      #1;
      chk("blk_idle0_after", slice_idle[0], 1);
      do_reset();
      m_r_valid = 1; m_r_id = {2'd2, 8'h00}; m_r_last = 1; s_r_ready = 4'b0100;
      step();
      m_r_valid = 0; m_r_last = 0;
      #1;
      chk("uf_err", err_sticky, 1);
      chk("uf_idle2", slice_idle[2], 1);
      step();
      do_reset();
      chk("uf_clear", err_sticky, 0);
      d3_m_r_valid = 1; d3_m_r_id = 10'h300; d3_s_r_ready = 3'b000;
      #1;
      chk("inv_ready", d3_m_r_ready, 1);
      chk("inv_s_r_valid", d3_s_r_valid, 0);
      chk("inv_err_pre", d3_err, 0);
      @(posedge clk);
      @(negedge clk);
      d3_m_r_valid = 0;
      #1;
      chk("inv_err", d3_err, 1);
      @(negedge clk);
      for (int c = 0; c < 3000; c++) begin
         int live [$];
         int rs;
         s_ar_valid = N'($urandom);
         slice_block = ($urandom % 4 == 0) ? N'($urandom) : '0;
         m_ar_ready = ($urandom % 4) != 0;
         s_ar_addr = {$urandom, $urandom, $urandom, $urandom};
         s_ar_len = $urandom;
         s_ar_id = $urandom;
         for (int i = 0; i < N; i++) if (cnt[i] > 0) live.push_back(i);
         if (live.size() > 0 && $urandom % 2 == 0) begin
            m_r_valid = 1; rs = live[$urandom % live.size()];
         end else begin
            m_r_valid = ($urandom % 8) == 0; rs = int'($urandom % N);
         end
         m_r_id = {S'(rs), T'($urandom)};
         m_r_last = ($urandom % 3) == 0;
         m_r_data = $urandom;
         s_r_ready = N'($urandom);
         reset = ($urandom % 300) == 0;
         step();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
